flash_burst_reader: RTL and testbench

Parametrised read-only controller for the 16-bit parallel NOR flash. It fetches bus-width words by reading LANES consecutive halfwords and packing them little-endian, so halfword n+1 lands above halfword n. Supports programmable access wait-states and multi-word sequential bursts with a per-word valid strobe. It sits between the bus/ROM arbiter and the flash pins and supersedes the fixed two-halfword, single-read flash reader.

---
 rtl/flash_burst_reader.sv | 130 +++++++++++++
 tb/tb_flash_burst_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_reader.sv
// Read-only burst controller for a 16-bit parallel NOR flash: packs LANES
// consecutive halfwords little-endian into one word, with programmable wait-states.
//
// state  | meaning
// IDLE   | chip deselected, waiting for req (only once flash_rp_n has released)
// ACCESS | driving flash_a, counting wait-states, sampling halfwords per word
module flash_burst_reader #(
    parameter int ADDR_W      = 22,
    parameter int DQ_W        = 16,
    parameter int LANES       = 2,
    parameter int WAIT_CYCLES = 4,
    parameter int BURST_W     = 4,
    parameter int DATA_W      = LANES * DQ_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BURST_W-1:0] burst_len,
    output logic               busy,
    output logic [DATA_W-1:0]  rdata,
    output logic               rvalid,
    output logic [ADDR_W-1:0]  flash_a,
    input  logic [DQ_W-1:0]    flash_dq,
    output logic               flash_ce_n,
    output logic               flash_oe_n,
    output logic               flash_we_n,
    output logic               flash_rp_n
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LANES - 1));

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   lane, lane_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [BURST_W-1:0]  words, words_nxt;
    logic [ADDR_W-1:0]   a_nxt;
    logic [DATA_W-1:0]   buffer, buf_nxt, sample_buf;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                rvalid_nxt;
    logic                rp_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lane    <= '0;
            cnt     <= '0;
            words   <= '0;
            flash_a <= '0;
            buffer  <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            rp_n    <= 1'b0;
        end else begin
            state   <= state_nxt;
            lane    <= lane_nxt;
            cnt     <= cnt_nxt;
            words   <= words_nxt;
            flash_a <= a_nxt;
            buffer  <= buf_nxt;
            rdata   <= rdata_nxt;
            rvalid  <= rvalid_nxt;
            rp_n    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        lane_nxt   = lane;
        cnt_nxt    = cnt;
        words_nxt  = words;
        a_nxt      = flash_a;
        buf_nxt    = buffer;
        rdata_nxt  = rdata;
        rvalid_nxt = 1'b0;
        // the word published on the last lane must include the halfword sampled this edge
        sample_buf = buffer;
        sample_buf[lane*DQ_W +: DQ_W] = flash_dq;

        case (state)
            IDLE: begin
                if (req && rp_n) begin
                    state_nxt = ACCESS;
                    a_nxt     = addr & ALIGN_MASK;
                    lane_nxt  = '0;
                    cnt_nxt   = CNT_RELOAD;
                    words_nxt = (burst_len == '0) ? BURST_W'(1) : burst_len;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    buf_nxt = sample_buf;
                    if (lane != LANE_LAST) begin
                        lane_nxt = lane + LANE_W'(1);
                        a_nxt    = flash_a + ADDR_W'(1);
                        cnt_nxt  = CNT_RELOAD;
                    end else begin
                        rdata_nxt  = sample_buf;
                        rvalid_nxt = 1'b1;
                        words_nxt  = words - BURST_W'(1);
                        if (words > BURST_W'(1)) begin
                            a_nxt    = flash_a + ADDR_W'(1);
                            lane_nxt = '0;
                            cnt_nxt  = CNT_RELOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state == ACCESS);
    assign flash_ce_n = ~busy;
    assign flash_oe_n = ~busy;
    assign flash_we_n = 1'b1;
    assign flash_rp_n = rp_n;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader: default build plus LANES=1/WAIT=1 and
// LANES=4/WAIT=3 builds, each against a flash returning {a[7:0], ~a[7:0]}.
module tb_flash_burst_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default instance
    logic        req = 1'b0;
    logic [21:0] addr = '0;
    logic [3:0]  burst_len = '0;
    logic        busy, rvalid, ce_n, oe_n, we_n, rp_n;
    logic [31:0] rdata;
    logic [21:0] fa;
    logic [15:0] dq;
    assign dq = {fa[7:0], ~fa[7:0]};

    flash_burst_reader u_dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .burst_len(burst_len),
        .busy(busy), .rdata(rdata), .rvalid(rvalid), .flash_a(fa), .flash_dq(dq),
        .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n), .flash_rp_n(rp_n)
    );

    // LANES=1, WAIT_CYCLES=1
    logic        req1 = 1'b0;
    logic [21:0] addr1 = '0;
    logic [3:0]  bl1 = '0;
    logic        busy1, rvalid1, ce1, oe1, we1, rp1;
    logic [15:0] rdata1;
    logic [21:0] fa1;
    logic [15:0] dq1;
    assign dq1 = {fa1[7:0], ~fa1[7:0]};

    flash_burst_reader #(.LANES(1), .WAIT_CYCLES(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req1), .addr(addr1), .burst_len(bl1),
        .busy(busy1), .rdata(rdata1), .rvalid(rvalid1), .flash_a(fa1), .flash_dq(dq1),
        .flash_ce_n(ce1), .flash_oe_n(oe1), .flash_we_n(we1), .flash_rp_n(rp1)
    );

    // LANES=4, WAIT_CYCLES=3
    logic        req4 = 1'b0;
    logic [21:0] addr4 = '0;
    logic [3:0]  bl4 = '0;
    logic        busy4, rvalid4, ce4, oe4, we4, rp4;
    logic [63:0] rdata4;
    logic [21:0] fa4;
    logic [15:0] dq4;
    assign dq4 = {fa4[7:0], ~fa4[7:0]};

    flash_burst_reader #(.LANES(4), .WAIT_CYCLES(3)) u_l4 (
        .clk(clk), .rst(rst), .req(req4), .addr(addr4), .burst_len(bl4),
        .busy(busy4), .rdata(rdata4), .rvalid(rvalid4), .flash_a(fa4), .flash_dq(dq4),
        .flash_ce_n(ce4), .flash_oe_n(oe4), .flash_we_n(we4), .flash_rp_n(rp4)
    );

    // drive a one-cycle request on the default instance; returns 1ns after E0
    task automatic start(input logic [21:0] a, input logic [3:0] bl);
        @(negedge clk);
        req = 1'b1; addr = a; burst_len = bl;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, rvalid, ce_n, oe_n, we_n, rp_n} !== 6'b001110) begin
            errors++;
            $display("FAIL reset_ctrl got busy,rvalid,ce_n,oe_n,we_n,rp_n=%b want 001110",
                     {busy, rvalid, ce_n, oe_n, we_n, rp_n});
        end
        checks++;
        if (rdata !== 32'h0 || fa !== 22'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h flash_a=%h want 0/0", rdata, fa);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (rp_n !== 1'b0) begin
            errors++;
            $display("FAIL rp_before_edge got %b want 0", rp_n);
        end
        @(posedge clk); #1;
        checks++;
        if (rp_n !== 1'b1) begin
            errors++;
            $display("FAIL rp_after_edge got %b want 1", rp_n);
        end
    endtask

    task automatic test_single;
        start(22'h10, 4'd1);
        checks++;
        if (busy !== 1'b1 || ce_n !== 1'b0 || oe_n !== 1'b0 || fa !== 22'h10) begin
            errors++;
            $display("FAIL single_accept got busy=%b ce_n=%b oe_n=%b a=%h want 1 0 0 10",
                     busy, ce_n, oe_n, fa);
        end
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== (i == 8) || busy !== (i < 8)) begin
                errors++;
                $display("FAIL single_timing cyc=%0d got rvalid=%b busy=%b want %b %b",
                         i, rvalid, busy, i == 8, i < 8);
            end
            if (i == 4) begin
                checks++;
                if (fa !== 22'h11) begin
                    errors++;
                    $display("FAIL single_lane1_addr got %h want 11", fa);
                end
            end
            if (i == 8) begin
                checks++;
                if (rdata !== 32'h11EE10EF) begin
                    errors++;
                    $display("FAIL single_rdata got %h want 11EE10EF", rdata);
                end
            end
        end
        checks++;
        if (ce_n !== 1'b1 || oe_n !== 1'b1) begin
            errors++;
            $display("FAIL single_deselect got ce_n=%b oe_n=%b want 1 1", ce_n, oe_n);
        end
    endtask

    task automatic test_align;
        start(22'h13, 4'd1);
        checks++;
        if (fa !== 22'h12) begin
            errors++;
            $display("FAIL align_addr got %h want 12", fa);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h13EC12ED) begin
            errors++;
            $display("FAIL align_rdata got rvalid=%b rdata=%h want 1 13EC12ED", rvalid, rdata);
        end
    endtask

    task automatic test_burst_wrap;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFF00FE01;
        exp_w[1] = 32'h01FE00FF;
        exp_w[2] = 32'h03FC02FD;
        start(22'h3FFFFE, 4'd3);
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== (i % 8 == 0 && i <= 24) || busy !== (i < 24)) begin
                errors++;
                $display("FAIL burst_timing cyc=%0d got rvalid=%b busy=%b", i, rvalid, busy);
            end
            if (i == 8) begin
                checks++;
                if (fa !== 22'h0) begin
                    errors++;
                    $display("FAIL burst_wrap_addr got %h want 0", fa);
                end
            end
            if (i % 8 == 0 && i <= 24) begin
                checks++;
                if (rdata !== exp_w[i/8-1]) begin
                    errors++;
                    $display("FAIL burst_word%0d got %h want %h", i/8-1, rdata, exp_w[i/8-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req = 1'b1; addr = 22'h40; burst_len = 4'd0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b want 1", busy);
        end
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== (i == 8 || i == 17) || busy !== (i != 8 && i != 17)) begin
                errors++;
                $display("FAIL b2b_timing cyc=%0d got rvalid=%b busy=%b", i, rvalid, busy);
            end
            if (i == 8 || i == 17) begin
                checks++;
                if (rdata !== 32'h41BE40BF) begin
                    errors++;
                    $display("FAIL b2b_rdata cyc=%0d got %h want 41BE40BF", i, rdata);
                end
            end
        end
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b rvalid=%b want 0 0", busy, rvalid);
        end
    endtask

    task automatic test_reset_mid;
        int rv_seen;
        start(22'h100, 4'd3);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1; #1;
        checks++;
        if ({busy, rvalid, ce_n, oe_n, we_n, rp_n} !== 6'b001110) begin
            errors++;
            $display("FAIL midrst_ctrl got busy,rvalid,ce_n,oe_n,we_n,rp_n=%b want 001110",
                     {busy, rvalid, ce_n, oe_n, we_n, rp_n});
        end
        checks++;
        if (rdata !== 32'h0 || fa !== 22'h0) begin
            errors++;
            $display("FAIL midrst_data got rdata=%h flash_a=%h want 0/0", rdata, fa);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (rp_n !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rp_hold got %b want 0", rp_n);
        end
        rv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rvalid === 1'b1 || busy === 1'b1) rv_seen++;
            if (i == 0) begin
                checks++;
                if (rp_n !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_rp_release got %b want 1", rp_n);
                end
            end
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", rv_seen);
        end
    endtask

    task automatic test_params;
        logic [7:0]  b;
        logic [15:0] exp16;
        @(negedge clk);
        req1 = 1'b1; addr1 = 22'h5; bl1 = 4'd4;
        @(posedge clk); #1;
        req1 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid1 !== (i <= 4) || busy1 !== (i < 4)) begin
                errors++;
                $display("FAIL l1_timing cyc=%0d got rvalid=%b busy=%b", i, rvalid1, busy1);
            end
            if (i <= 4) begin
                b = 8'(4 + i);
                exp16 = {b, ~b};
                checks++;
                if (rdata1 !== exp16) begin
                    errors++;
                    $display("FAIL l1_rdata cyc=%0d got %h want %h", i, rdata1, exp16);
                end
            end
        end
        @(negedge clk);
        req4 = 1'b1; addr4 = 22'h20; bl4 = 4'd1;
        @(posedge clk); #1;
        req4 = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid4 !== (i == 12) || busy4 !== (i < 12)) begin
                errors++;
                $display("FAIL l4_timing cyc=%0d got rvalid=%b busy=%b", i, rvalid4, busy4);
            end
            if (i == 12) begin
                checks++;
                if (rdata4 !== 64'h23DC22DD21DE20DF) begin
                    errors++;
                    $display("FAIL l4_rdata got %h want 23DC22DD21DE20DF", rdata4);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_align;
        test_burst_wrap;
        test_back_to_back;
        test_reset_mid;
        test_params;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
